// File: rtl/counter1_seq_arb.sv
// Round-robin sequencer for the shared 1-bit toggle counter: grants one requester,
// clears the counter, enables it for N cycles, drains the gate pipeline, returns the count.
module counter1_seq_arb #(
  parameter int LEN_W   = 4,
  parameter int CNT_LAT = 3,
  parameter int RST_CYC = 4
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             req0_Pad,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1_Pad,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             cnt_rst_Pad,
  output logic             cnt_en_Pad,
  input  logic             count_Pad,
  output logic             done,
  output logic             result,
  output logic             err,
  output logic             busy
);

  localparam int CLR_W = $clog2(RST_CYC + 1);
  localparam int DRN_W = $clog2(CNT_LAT + 1);
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(RST_CYC - 1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(CNT_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic             rr_last;
  logic             win;
  logic [LEN_W-1:0] n;
  logic [LEN_W-1:0] run_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic [DRN_W-1:0] drn_cnt;

  // Returns 1 when requester 1 should be granted; ties go to the one not served last.
  function automatic logic pick_one(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  // The counter toggles once per enabled cycle, so a healthy count equals N's LSB.
  function automatic logic parity_err(input logic cnt, input logic [LEN_W-1:0] len);
    return cnt ^ len[0];
  endfunction

  always_comb win = pick_one(req0_Pad, req1_Pad, rr_last);

  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      cnt_rst_Pad <= 1'b1;
      cnt_en_Pad  <= 1'b0;
      done        <= 1'b0;
      result      <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      rr_last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_rst_Pad <= 1'b1;
          cnt_en_Pad  <= 1'b0;
          done        <= 1'b0;
          if (req0_Pad || req1_Pad) begin
            gnt     <= win ? 2'b10 : 2'b01;
            n       <= win ? len1 : len0;
            rr_last <= win;
            clr_cnt <= CLR_LOAD;
            busy    <= 1'b1;
            state   <= CLR;
          end
        end
        CLR: begin
          if (clr_cnt == '0) begin
            cnt_rst_Pad <= 1'b0;
            if (n != '0) begin
              cnt_en_Pad <= 1'b1;
              run_cnt    <= n - LEN_W'(1);
              state      <= RUN;
            end else begin
              drn_cnt <= DRN_LOAD;
              state   <= DRAIN;
            end
          end else begin
            clr_cnt <= clr_cnt - CLR_W'(1);
          end
        end
        RUN: begin
          if (run_cnt == '0) begin
            cnt_en_Pad <= 1'b0;
            drn_cnt    <= DRN_LOAD;
            state      <= DRAIN;
          end else begin
            run_cnt <= run_cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          // The last enabled toggle has landed on count_Pad by the final drain cycle.
          if (drn_cnt == '0) begin
            done   <= 1'b1;
            result <= count_Pad;
            err    <= parity_err(count_Pad, n);
            state  <= DONE;
          end else begin
            drn_cnt <= drn_cnt - DRN_W'(1);
          end
        end
        DONE: begin
          done        <= 1'b0;
          gnt         <= 2'b00;
          busy        <= 1'b0;
          cnt_rst_Pad <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter1_seq_arb.sv
// Bench for counter1_seq_arb: a 3-cycle-latency toggle counter model, a table of
// request patterns, a scoreboard of expected bursts, and hand-written reset/drop cases.
module tb_counter1_seq_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] len0, len1;
  logic [1:0] gnt;
  logic       cnt_rst, cnt_en, count;
  logic       done, result, err, busy;

  counter1_seq_arb #(.LEN_W(4), .CNT_LAT(3), .RST_CYC(4)) dut (
    .GCLK_Pad(clk), .rst_Pad(rst),
    .req0_Pad(req0), .len0(len0), .req1_Pad(req1), .len1(len1),
    .gnt(gnt), .cnt_rst_Pad(cnt_rst), .cnt_en_Pad(cnt_en), .count_Pad(count),
    .done(done), .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter model: en/rst take effect on count three edges after they change.
  logic stick;
  logic en_d1, en_d2, rs_d1, rs_d2, cnt_q;
  always @(posedge clk) begin
    en_d1 <= cnt_en;
    en_d2 <= en_d1;
    rs_d1 <= cnt_rst;
    rs_d2 <= rs_d1;
    cnt_q <= rs_d2 ? 1'b0 : (cnt_q ^ en_d2);
  end
  assign count = stick ? 1'b0 : cnt_q;

  typedef struct {
    logic [1:0] g;
    logic [3:0] n;
    logic       res;
    logic       er;
  } exp_t;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] l0;
    logic [3:0] l1;
    logic       stk;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_push = 0;
  int   done_seen = 0;
  logic rr_m = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input logic idx, input logic [3:0] nv);
    exp_t e;
    e.g   = idx ? 2'b10 : 2'b01;
    e.n   = nv;
    e.res = stick ? 1'b0 : nv[0];
    e.er  = stick ? nv[0] : 1'b0;
    sb.push_back(e);
    n_push++;
    rr_m = idx;
  endtask

  // Monitor: tracks each grant window and checks it against the scoreboard at done.
  int   cyc = 0, en_n = 0, en_rise = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (busy) chk("gnt_onehot", {31'b0, $onehot(gnt)}, 1);
    else      chk("gnt_idle_zero", {30'b0, gnt}, 0);
    if (gnt == 2'b00) begin
      cyc = 0; en_n = 0; en_rise = 0; prev_en = 1'b0;
    end else begin
      cyc++;
      if (cnt_en) en_n++;
      if (cnt_en && !prev_en) en_rise++;
      prev_en = cnt_en;
      if (cnt_en && cnt_rst) chk("en_with_rst", 1, 0);
    end
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_gnt", {30'b0, gnt}, {30'b0, e.g});
        chk("result", {31'b0, result}, {31'b0, e.res});
        chk("err", {31'b0, err}, {31'b0, e.er});
        chk("latency", cyc, 8 + int'(e.n));
        chk("en_cycles", en_n, int'(e.n));
        chk("en_bursts", en_rise, (e.n != 0) ? 1 : 0);
      end
    end
  end

  // Hold requests until each one's done pulse, with a cycle budget.
  task automatic finish_reqs(input int budget);
    for (int c = 0; c < budget && (req0 || req1); c++) begin
      @(negedge clk);
      if (done && gnt[0]) req0 = 1'b0;
      if (done && gnt[1]) req1 = 1'b0;
    end
    if (req0 || req1) begin
      chk("req_timeout", 1, 0);
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_burst(input vec_t v);
    stick = v.stk;
    if (v.r0 && v.r1) begin
      logic first;
      first = rr_m ? 1'b0 : 1'b1;
      push(first, first ? v.l1 : v.l0);
      push(~first, first ? v.l0 : v.l1);
    end else if (v.r0) begin
      push(1'b0, v.l0);
    end else if (v.r1) begin
      push(1'b1, v.l1);
    end
    len0 = v.l0; len1 = v.l1;
    req0 = v.r0; req1 = v.r1;
    finish_reqs(400);
  endtask

  task automatic wait_en(input int budget);
    int c;
    c = 0;
    while (!cnt_en && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!cnt_en) chk("en_timeout", 1, 0);
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{r0: 1'b1, r1: 1'b1, l0: 4'd2,  l1: 4'd2,  stk: 1'b0};
    vt[1] = '{r0: 1'b1, r1: 1'b0, l0: 4'd5,  l1: 4'd0,  stk: 1'b0};
    vt[2] = '{r0: 1'b1, r1: 1'b1, l0: 4'd2,  l1: 4'd2,  stk: 1'b0};
    vt[3] = '{r0: 1'b0, r1: 1'b1, l0: 4'd7,  l1: 4'd0,  stk: 1'b0};
    vt[4] = '{r0: 1'b1, r1: 1'b0, l0: 4'd15, l1: 4'd0,  stk: 1'b1};
    vt[5] = '{r0: 1'b0, r1: 1'b1, l0: 4'd0,  l1: 4'd15, stk: 1'b0};
    vt[6] = '{r0: 1'b1, r1: 1'b1, l0: 4'd7,  l1: 4'd3,  stk: 1'b0};

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0; stick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'b0, gnt}, 0);
    chk("rst_cnt_rst", {31'b0, cnt_rst}, 1);
    chk("rst_cnt_en", {31'b0, cnt_en}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", {31'b0, result}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_burst(vt[i]);

    // Reset pulse in the middle of an N=9 run aborts it; the held request is re-granted.
    stick = 1'b0;
    len0 = 4'd9; req0 = 1'b1;
    wait_en(20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gnt", {30'b0, gnt}, 0);
    chk("abort_cnt_en", {31'b0, cnt_en}, 0);
    chk("abort_cnt_rst", {31'b0, cnt_rst}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    rr_m = 1'b1;
    push(1'b0, 4'd9);
    rst = 1'b0;
    finish_reqs(100);

    // Length change after grant and request dropped mid-run: latched N still completes.
    push(1'b0, 4'd6);
    len0 = 4'd6; req0 = 1'b1;
    for (int c = 0; c < 10 && !gnt[0]; c++) @(negedge clk);
    chk("drop_granted", {31'b0, gnt[0]}, 1);
    len0 = 4'd3;
    wait_en(20);
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk);
    repeat (5) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    chk("done_count", done_seen, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
